// File: rtl/spi_target_regfile_if.sv
// spi_target_regfile_if: SPI target-side serial signals between a master and the register file.
interface spi_target_regfile_if;
   logic cs_n;
   logic mosi;
   logic miso;
   logic miso_oe;
   modport master(output cs_n, mosi, input miso, miso_oe);
   modport slave(input cs_n, mosi, output miso, miso_oe);
endinterface

// File: rtl/spi_target_regfile.sv
// spi_target_regfile: CPOL=1/CPHA=1 SPI target with command byte and auto-incrementing register file.
module spi_target_regfile #(
   parameter int          NUM_REGS  = 4,
   parameter int          ADDR_W    = 2,
   parameter logic [7:0]  ID_BYTE   = 8'hA5,
   parameter logic [7:0]  RESET_VAL = 8'h00
) (
   input  logic                    SCLK,
   input  logic                    reset_n,
   spi_target_regfile_if.slave     spi,
   output logic [8*NUM_REGS-1:0]   reg_out,
   output logic                    wr_valid,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [3:0]              byte_cnt
);
   typedef enum logic {CMD, DATA} state_t;
   state_t              state, state_nxt;
   logic [2:0]          bit_cnt;
   logic [7:0]          rx_shift, tx_shift, tx_byte, rx_byte;
   logic                rw;
   logic [ADDR_W-1:0]   addr;
   logic [7:0]          regs [NUM_REGS];
   logic                frame_rst, byte_done;
   assign frame_rst = !reset_n || spi.cs_n;
   assign byte_done = bit_cnt == 3'd7;
   assign rx_byte = {rx_shift[6:0], spi.mosi};
   assign spi.miso_oe = !spi.cs_n;
   always_ff @(posedge SCLK or posedge frame_rst)
      if (frame_rst) state <= CMD;
      else state <= state_nxt;
   always_comb state_nxt = (state == CMD && byte_done) ? DATA : state;
   always_comb tx_byte = state == CMD ? ID_BYTE : rw ? regs[addr] : 8'h00;
   always_ff @(posedge SCLK or posedge frame_rst)
      if (frame_rst) begin
         bit_cnt <= '0;
         byte_cnt <= '0;
         rx_shift <= '0;
         rw <= 1'b0;
         addr <= '0;
         wr_valid <= 1'b0;
      end else begin
         bit_cnt <= bit_cnt + 3'd1;
         rx_shift <= rx_byte;
         wr_valid <= byte_done && state == DATA && !rw;
         if (byte_done) begin
            byte_cnt <= byte_cnt == 4'd15 ? byte_cnt : byte_cnt + 4'd1;
            rw <= state == CMD ? rx_byte[7] : rw;
            addr <= state == CMD ? rx_byte[ADDR_W-1:0] : addr + ADDR_W'(1);
         end
      end
   // Register contents and wr_addr survive a cs_n frame clear, so only reset_n clears them.
   always_ff @(posedge SCLK or negedge reset_n)
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
         wr_addr <= '0;
      end else if (!spi.cs_n && state == DATA && !rw && byte_done) begin
         regs[addr] <= rx_byte;
         wr_addr <= addr;
      end
   // Read data is captured at the first falling edge of each byte.
   always_ff @(negedge SCLK or posedge frame_rst)
      if (frame_rst) begin
         spi.miso <= 1'b1;
         tx_shift <= '0;
      end else if (bit_cnt == 3'd0) begin
         spi.miso <= tx_byte[7];
         tx_shift <= {tx_byte[6:0], 1'b0};
      end else begin
         spi.miso <= tx_shift[7];
         tx_shift <= {tx_shift[6:0], 1'b0};
      end
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_out[8*g +: 8] = regs[g];
   end
endmodule

// File: tb/tb_spi_target_regfile.sv
// tb_spi_target_regfile: directed SPI frames against hand-computed MISO bytes and register contents.
module tb_spi_target_regfile;
   logic        SCLK = 1'b1;
   logic        reset_n = 1'b0;
   logic [31:0] reg_out;
   logic        wr_valid;
   logic [1:0]  wr_addr;
   logic [3:0]  byte_cnt;
   logic [7:0]  rx;
   int          passed = 0, total = 0, pulses = 0;
   spi_target_regfile_if spi();
   spi_target_regfile dut (
      .SCLK(SCLK), .reset_n(reset_n), .spi(spi),
      .reg_out(reg_out), .wr_valid(wr_valid), .wr_addr(wr_addr), .byte_cnt(byte_cnt)
   );
   always @(posedge wr_valid) pulses++;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   // Mode 3 master: drive MOSI on falling edge, sample MISO just before rising edge.
   task automatic bits(input logic [7:0] tx, input int n, output logic [7:0] r);
      r = '0;
      for (int i = 0; i < n; i++) begin
         SCLK = 1'b0;
         spi.mosi = tx[7-i];
         #4 r[7-i] = spi.miso;
         #1 SCLK = 1'b1;
         #5;
      end
   endtask
   task automatic xfer(input logic [7:0] tx, input logic [7:0] exp, input string tag);
      logic [7:0] r;
      bits(tx, 8, r);
      check(tag, {24'h0, r}, {24'h0, exp});
   endtask
   task automatic frame_start();
      spi.cs_n = 1'b0;
      #5;
   endtask
   task automatic frame_end();
      #5 spi.cs_n = 1'b1;
      #5;
   endtask
   initial begin
      spi.cs_n = 1'b1;
      spi.mosi = 1'b0;
      #10;
      check("rst_regs", reg_out, 32'h0);
      check("rst_miso", {31'h0, spi.miso}, 32'h1);
      check("rst_wrv", {31'h0, wr_valid}, 32'h0);
      check("rst_wra", {30'h0, wr_addr}, 32'h0);
      check("rst_bcnt", {28'h0, byte_cnt}, 32'h0);
      check("rst_oe", {31'h0, spi.miso_oe}, 32'h0);
      reset_n = 1'b1;
      #5;
      frame_start();
      check("oe_on", {31'h0, spi.miso_oe}, 32'h1);
      xfer(8'h00, 8'hA5, "w1_cmd");
      xfer(8'h3C, 8'h00, "w1_dat");
      check("w1_wrv", {31'h0, wr_valid}, 32'h1);
      check("w1_wra", {30'h0, wr_addr}, 32'h0);
      check("w1_bcnt", {28'h0, byte_cnt}, 32'h2);
      frame_end();
      check("w1_regs", reg_out, 32'h0000003C);
      check("w1_pulses", pulses, 32'd1);
      check("clr_bcnt", {28'h0, byte_cnt}, 32'h0);
      check("clr_wrv", {31'h0, wr_valid}, 32'h0);
      frame_start();
      xfer(8'h80, 8'hA5, "r1_cmd");
      xfer(8'h00, 8'h3C, "r1_dat");
      check("r1_wrv", {31'h0, wr_valid}, 32'h0);
      frame_end();
      check("r1_pulses", pulses, 32'd1);
      check("r1_regs", reg_out, 32'h0000003C);
      frame_start();
      xfer(8'h03, 8'hA5, "bw_cmd");
      xfer(8'h11, 8'h00, "bw_d0");
      check("bw_wra0", {30'h0, wr_addr}, 32'h3);
      xfer(8'h22, 8'h00, "bw_d1");
      check("bw_wra1", {30'h0, wr_addr}, 32'h0);
      xfer(8'h33, 8'h00, "bw_d2");
      check("bw_wra2", {30'h0, wr_addr}, 32'h1);
      check("bw_bcnt", {28'h0, byte_cnt}, 32'h4);
      frame_end();
      check("bw_regs", reg_out, 32'h11003322);
      check("bw_pulses", pulses, 32'd4);
      frame_start();
      xfer(8'h82, 8'hA5, "br_cmd");
      xfer(8'h00, 8'h00, "br_r2");
      xfer(8'h00, 8'h11, "br_r3");
      xfer(8'h00, 8'h22, "br_r0");
      xfer(8'h00, 8'h33, "br_r1");
      check("br_bcnt", {28'h0, byte_cnt}, 32'h5);
      frame_end();
      check("br_regs", reg_out, 32'h11003322);
      frame_start();
      xfer(8'h01, 8'hA5, "ab_cmd");
      bits(8'hFF, 5, rx);
      frame_end();
      check("ab_regs", reg_out, 32'h11003322);
      check("ab_bcnt", {28'h0, byte_cnt}, 32'h0);
      check("ab_miso", {31'h0, spi.miso}, 32'h1);
      check("ab_pulses", pulses, 32'd4);
      frame_start();
      xfer(8'h81, 8'hA5, "ab2_cmd");
      xfer(8'h00, 8'h33, "ab2_r1");
      frame_end();
      frame_start();
      xfer(8'h02, 8'hA5, "rs_cmd");
      bits(8'h5A, 4, rx);
      check("rs_pre_miso", {31'h0, spi.miso}, 32'h0);
      reset_n = 1'b0;
      #2;
      check("rs_regs", reg_out, 32'h0);
      check("rs_miso", {31'h0, spi.miso}, 32'h1);
      check("rs_wrv", {31'h0, wr_valid}, 32'h0);
      check("rs_wra", {30'h0, wr_addr}, 32'h0);
      check("rs_bcnt", {28'h0, byte_cnt}, 32'h0);
      #3 spi.cs_n = 1'b1;
      #5 reset_n = 1'b1;
      #5;
      frame_start();
      xfer(8'h80, 8'hA5, "sat_cmd");
      for (int i = 0; i < 19; i++) xfer(8'h00, 8'h00, "sat_dat");
      check("sat_bcnt", {28'h0, byte_cnt}, 32'hF);
      frame_end();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
